muldiv_alu: RTL and testbench

MULDIV_ALU -- requirements
Module: muldiv_alu

---
 rtl/muldiv_alu.sv | 252 +++++++++++++++++++++++++
 tb/tb_muldiv_alu.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu.sv
// -----------------------------------------------------------------------------
// muldiv_alu
//
// Iterative RV-M multiply/divide unit. One operation is in flight at a time:
// a request is accepted in IDLE, multiplies run a radix-2 shift-add and
// divides run a restoring shift-subtract on operand magnitudes for WIDTH
// cycles in CALC, and the sign-corrected result is presented in DONE until
// the consumer takes it. Divide-by-zero and signed-overflow divides skip
// CALC and go straight to DONE.
//
// Ports
//   clk        sole clock, rising-edge
//   rst        asynchronous, active-high reset
//   flush      synchronous kill of any operation in flight (highest priority)
//   in_valid   request carries a valid op and operands
//   in_ready   unit can accept a request this cycle (state == IDLE)
//   op[2:0]    RV-M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   A, B       rs1 / rs2 operands, WIDTH bits
//   out_valid  result is valid (state == DONE)
//   out_ready  consumer takes the result
//   result     operation result, WIDTH bits
//   div_zero   result came from a divide/remainder with B == 0
//
// Parameter
//   WIDTH      operand/result width, even, 8..64
// -----------------------------------------------------------------------------
module muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  // Iteration counter is log2(WIDTH)+1 bits wide.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operation and datapath state.
  logic [2:0]         r_op;
  logic               r_neg;      // final result must be negated
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   r_result;
  logic               r_div_zero;

  // ---------------------------------------------------------------------------
  // Accept-side decode: signedness, magnitudes and special cases, all taken
  // from the live inputs and only used on the accept cycle.
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_is_div;
  logic             w_dz_case;
  logic             w_ovf_case;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;

  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;

  assign w_is_div   = op[2];
  // A is signed for MUL, MULH, MULHSU, DIV, REM; B only for MUL, MULH, DIV, REM.
  assign w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                      (op == OP_DIV) || (op == OP_REM);

  assign w_a_neg    = w_a_signed && A[WIDTH-1];
  assign w_b_neg    = w_b_signed && B[WIDTH-1];
  // The most-negative value negates to itself, which is exactly its unsigned magnitude.
  assign w_a_mag    = w_a_neg ? -A : A;
  assign w_b_mag    = w_b_neg ? -B : B;

  assign w_dz_case  = w_is_div && (B == '0);
  // Signed overflow only exists for DIV/REM (op[0]==0 among the divide ops).
  assign w_ovf_case = w_is_div && !op[0] && (A == MOST_NEG) && (B == '1);
  assign w_special  = w_dz_case || w_ovf_case;

  // op[1] selects the remainder flavour within the divide group.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first; a
    // path that leaves it unassigned would infer a latch.
    w_special_res = '0;
    if (w_dz_case) begin
      w_special_res = op[1] ? A : '1;
    end else if (w_ovf_case) begin
      w_special_res = op[1] ? '0 : A;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step.
  // ---------------------------------------------------------------------------
  // Shift-add multiply: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right,
  // catching the carry in the top bit.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits, and shift the quotient bit in at the LSB.
  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and a successful difference fits in WIDTH bits.
  logic [WIDTH:0]     w_div_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_nxt;

  assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
  assign w_div_nxt  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Sign fix-up of the final iteration's value. Negating zero yields zero, so
  // a zero quotient or remainder is never turned negative.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_div_val;
  logic [WIDTH-1:0]   w_div_fix;
  logic [WIDTH-1:0]   w_final;

  assign w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_div_val  = r_op[1] ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
  assign w_div_fix  = r_neg ? -w_div_val : w_div_val;

  always_comb begin
    w_final = w_div_fix;
    if (!r_op[2]) begin
      w_final = (r_op[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0]
                                     : w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      // Flush outranks both accept and the output handoff.
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC: if (w_last)   w_state_nxt = S_DONE;
        // Returning to IDLE takes a cycle, so no accept overlaps the handoff.
        S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        default:              w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole datapath is cleared on reset; it is a handful of flops,
      // not a memory array, and a known reset value is part of the contract.
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= '0;
      if (w_special) begin
        r_result   <= w_special_res;
        r_div_zero <= w_dz_case;
      end else begin
        // Multiplier (B) or dividend (A) goes into the low half.
        r_acc  <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
        // Remainder follows the dividend's sign; products and quotients are
        // negative when exactly one operand is.
        r_neg  <= (w_is_div && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result   <= w_final;
        r_div_zero <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_muldiv_alu.sv
// -----------------------------------------------------------------------------
// tb_muldiv_alu
//
// Self-checking bench for muldiv_alu at WIDTH=32. Table-driven vectors with
// constant expectations, a behavioural reference for random vectors, and
// hand-written sequences for backpressure, flush and asynchronous reset.
// Expected results go into a scoreboard queue when a request is driven and
// are popped by a monitor when the DUT hands a result off.
// -----------------------------------------------------------------------------
module tb_muldiv_alu;

  localparam int W = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_zero;

  muldiv_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built on the language's own arithmetic.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic signed [65:0] sa, sb, ua, ub, p;
    int           si, sj;
    logic [W-1:0] r;
    logic         dz;
    sa = {{34{a[31]}}, a};
    sb = {{34{b[31]}}, b};
    ua = {34'd0, a};
    ub = {34'd0, b};
    si = a;
    sj = b;
    r  = '0;
    dz = 1'b0;
    p  = '0;
    case (o)
      OP_MUL:    begin p = sa * sb; r = p[31:0];  end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV: begin
        if (b == 0) begin r = '1; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = si / sj;
      end
      OP_DIVU: begin
        if (b == 0) begin r = '1; dz = 1'b1; end
        else r = a / b;
      end
      OP_REM: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = si % sj;
      end
      default: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = a % b;
      end
    endcase
    return {dz, r};
  endfunction

  // Monitor: a handoff happens on the edge after a cycle with
  // out_valid && out_ready and no flush; sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_result", {32'd0, result}, {32'd0, e.res});
          check("sb_div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        end
      end
    end
  end

  // Drive a request; returns #1 after the accept edge with operands scrambled.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic edz);
    int guard;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op = o;
    A  = a;
    B  = b;
    e.res = er;
    e.dz  = edz;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    A  = $urandom;
    B  = $urandom;
  endtask

  // Count cycles from the accept edge to out_valid (1 = right after accept).
  task automatic wait_out(input string name, input int elat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic edz,
                        input int elat);
    send(o, a, b, er, edz);
    wait_out(name, elat);
    @(posedge clk);
    #2;
  endtask

  vec_t vecs[22];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        1'b0, 33};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         1'b0, 33};
    vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1'b1, 1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    vecs[12] = '{OP_MUL,    32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[13] = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33};
    vecs[14] = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
    vecs[15] = '{OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[16] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 33};
    vecs[17] = '{OP_DIV,    32'd0,          32'hFFFF_FFFD, 32'd0,         1'b0, 33};
    vecs[18] = '{OP_REM,    32'hFFFF_FFFA,  32'd3,         32'd0,         1'b0, 33};
    vecs[19] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[20] = '{OP_DIVU,   32'd0,          32'd0,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[21] = '{OP_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0; out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result",    {32'd0, result},    64'd0);
    check("rst_div_zero",  {63'd0, div_zero},  64'd0);
    rst = 1'b0;

    // Table vectors; the first is accepted on the first edge after reset.
    for (int i = 0; i < 22; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].dz, vecs[i].lat);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      logic [W:0]   m;
      int           el;
      ro = 3'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      m  = model(ro, ra, rb);
      el = (ro[2] && (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33;
      run_op($sformatf("rnd%0d", i), ro, ra, rb, m[W-1:0], m[W], el);
    end

    // Backpressure: result held and in_ready low for 10 cycles.
    out_ready = 1'b0;
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    wait_out("bp", 33);
    for (int i = 0; i < 10; i++) begin
      check("bp_result",    {32'd0, result},    64'h0000_0000_FFFF_FFFE);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
      @(posedge clk);
      #1;
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    #1;

    // Flush at CALC cycle 5: nothing is ever presented.
    send(OP_MUL, 32'd100, 32'd200, 32'd20000, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    flush = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    check("flush_in_ready",  {63'd0, in_ready},  64'd1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("flush_no_out_valid", 64'(seen), 64'd0);
    end
    #1;
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);

    // Flush beats the output handoff in DONE.
    send(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_out("flush_done", 1);
    #1;
    flush = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    check("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_done_in_ready",  {63'd0, in_ready},  64'd1);
    #1;

    // Flush beats accept in IDLE.
    in_valid = 1'b1;
    op = OP_MUL; A = 32'd2; B = 32'd2;
    @(posedge clk);
    #1;
    check("flush_vs_accept_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    flush = 1'b0;
    #1;

    // Asynchronous reset mid-CALC, then immediate accept.
    send(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    void'(sb_q.pop_back());
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_result",    {32'd0, result},    64'd0);
    rst = 1'b0;
    run_op("div_after_rst", OP_DIV, 32'd9, 32'd3, 32'd3, 1'b0, 33);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
